accelerator_tensor_fixed_elementwise_multiplier: RTL and testbench
==================================================================

# accelerator_tensor_fixed_elementwise_multiplier

Parametrised element-wise (Hadamard) multiplier for rank-3 signed fixed-point tensors, streaming one element pair per cycle in i/j/k order with k fastest. Next generation of the tensor fixed-point arithmetic layer: adds a configurable Q-format binary point, round-half-up, optional saturation, and sticky overflow and index-error status. It also adds a pipelined one-element-per-cycle datapath with framing markers regenerated on the output.

## Interface
- DATA_SIZE, 64, element width in bits, signed two's complement
- CONTROL_SIZE, 64, width of the size inputs and internal index counters
- FRACTION_SIZE, 32, number of fractional bits in the Q format; legal range 1..DATA_SIZE-1
- SATURATE, 1, 1 = clamp out-of-range results, 0 = truncate (wrap)
- CLK  in  1  clock; all state on the rising edge
- RST  in  1  asynchronous, active-low reset
- START  in  1  one-cycle pulse; starts a run, accepted only in STARTER_STATE
- READY  out  1  one-cycle pulse at end of run
- DATA_A_IN_I_ENABLE / DATA_A_IN_J_ENABLE / DATA_A_IN_K_ENABLE  in  1 each  A framing markers
- DATA_B_IN_I_ENABLE / DATA_B_IN_J_ENABLE / DATA_B_IN_K_ENABLE  in  1 each  B framing markers
- DATA_OUT_I_ENABLE / DATA_OUT_J_ENABLE / DATA_OUT_K_ENABLE  out  1 each  output framing markers
- SIZE_I_IN / SIZE_J_IN / SIZE_K_IN  in  CONTROL_SIZE each  tensor dimensions, unsigned
- DATA_A_IN / DATA_B_IN  in  DATA_SIZE each  operand elements
- DATA_OUT  out  DATA_SIZE  product element
- OVERFLOW  out  1  sticky; a result was clamped or wrapped this run
- INDEX_ERROR  out  1  sticky; an I/J marker disagreed with the internal counters this run

## Operation
- States: STARTER_STATE (idle), INPUT_STATE (accepting), ENDER_STATE (drain).
- STARTER → START=1: latch the three sizes, clear i/j/k counters, clear OVERFLOW and INDEX_ERROR.
  - If any size is 0: go to ENDER_STATE with no elements.
  - Otherwise: go to INPUT_STATE.
- Element accept: in INPUT_STATE, in any cycle where DATA_A_IN_K_ENABLE & DATA_B_IN_K_ENABLE = 1.
  - If either K marker is low, nothing is accepted and the counters hold (the stream may stall freely).
- Marker check on each accepted element:
  - Expected J marker = (k==0); expected I marker = (j==0 && k==0).
  - Any A or B I/J marker that differs from its expected value sets INDEX_ERROR.
  - The element is still processed.
- Counter advance: k increments. On k==SIZE_K-1, k wraps to 0 and j increments. On j==SIZE_J-1, j wraps to 0 and i increments.
- Last element accepted (i,j,k all at their maxima): go to ENDER_STATE. Further K markers are ignored.
- ENDER_STATE: wait for the pipeline to empty, pulse READY, return to STARTER_STATE.
- START outside STARTER_STATE is ignored. Sizes are sampled only at START.
- Arithmetic:
  - p = signed(A)·signed(B), 2·DATA_SIZE bits.
  - r = (p + 2^(FRACTION_SIZE-1)) >>> FRACTION_SIZE (arithmetic shift; round half toward +∞).
  - If r lies outside [-2^(DATA_SIZE-1), 2^(DATA_SIZE-1)-1]: set OVERFLOW, and output the clamped limit when SATURATE=1 or the low DATA_SIZE bits of r when SATURATE=0.
- Output markers: DATA_OUT_K_ENABLE=1 for every result. DATA_OUT_J_ENABLE and DATA_OUT_I_ENABLE are regenerated from the internal counters (not copied from the inputs), so they are correct even when INDEX_ERROR is set.

## Timing
- Reset (RST=0) values, applied immediately:
  - FSM = STARTER_STATE; counters = 0.
  - READY, all DATA_OUT_*_ENABLE, OVERFLOW, INDEX_ERROR = 0; DATA_OUT = 0.
  - Pipeline valid bits cleared.
- Reset mid-run aborts the run. No partial READY and no further outputs are produced.
- Pipeline depth 2:
  - Stage 1 registers p and the markers.
  - Stage 2 registers the rounded/saturated result, markers and OVERFLOW update.
  - An element accepted in cycle t appears on DATA_OUT, with its enables, in cycle t+2.
- Throughput: one element per cycle. The block never back-pressures.
- DATA_OUT_*_ENABLE are high for exactly one cycle per result. DATA_OUT holds its last value otherwise.
- READY:
  - Normal run: asserted in the same cycle as the last result's DATA_OUT_K_ENABLE.
  - Zero-size run: START in cycle t gives READY in cycle t+2 and no outputs.
- A new START is accepted in the cycle after READY.
- OVERFLOW and INDEX_ERROR update together with the offending result in stage 2. They hold until the next accepted START or reset.

## Test plan
- DATA_SIZE=16, FRACTION_SIZE=8, sizes 1×1×1: A=0x0180 (1.5), B=0x0200 (2.0) → DATA_OUT=0x0300 with I/J/K enables all 1 two cycles after accept; READY in the same cycle; OVERFLOW=0.
- Rounding and sign: A=0x0001, B=0x0080 → 0x0001; A=0xFF80 (−0.5), B=0x0100 → 0xFF80; OVERFLOW=0.
- Saturation: A=0x7F00, B=0x0200, SATURATE=1 → 0x7FFF, OVERFLOW=1. Same operands with SATURATE=0 → 0xFE00, OVERFLOW=1. Next START clears OVERFLOW.
- Sizes 2×2×3 with random stalls (K markers low): exactly 12 outputs in order.
  - DATA_OUT_J_ENABLE on outputs 0,3,6,9; DATA_OUT_I_ENABLE on outputs 0,6.
  - READY with output 11; INDEX_ERROR=0.
- Same stream with A_J_ENABLE wrongly high on element 1 → INDEX_ERROR=1 from output 1 onward; all 12 products still correct.
- SIZE_J_IN=0 → READY two cycles after START, no outputs. Separately, RST low mid-run → all outputs 0 immediately, no READY, and a subsequent run is correct.

Source files
------------

// File: rtl/accelerator_tensor_fixed_elementwise_multiplier.sv
// Streaming Hadamard multiplier for rank-3 signed Q-format tensors.
// Two-stage pipeline: product, then round/saturate with sticky status.

module fixed_round_sat #(
  parameter int DATA_SIZE     = 64,
  parameter int FRACTION_SIZE = 32,
  parameter bit SATURATE      = 1'b1
) (
  input  logic signed [2*DATA_SIZE-1:0] prod,
  output logic        [DATA_SIZE-1:0]   res,
  output logic                          ovf
);
  localparam logic signed [2*DATA_SIZE-1:0] HALF =
    {{(2*DATA_SIZE-1){1'b0}}, 1'b1} << (FRACTION_SIZE-1);

  logic signed [2*DATA_SIZE-1:0] rnd, r;
  logic [DATA_SIZE:0] hi;

  assign rnd = prod + HALF;
  assign r   = rnd >>> FRACTION_SIZE;
  // in range iff every bit above the result sign bit copies it
  assign hi  = r[2*DATA_SIZE-1:DATA_SIZE-1];
  assign ovf = !((&hi) || !(|hi));

  always_comb begin
    res = r[DATA_SIZE-1:0];
    if (ovf && SATURATE)
      res = r[2*DATA_SIZE-1] ? {1'b1, {(DATA_SIZE-1){1'b0}}}
                             : {1'b0, {(DATA_SIZE-1){1'b1}}};
  end
endmodule

module accelerator_tensor_fixed_elementwise_multiplier #(
  parameter int DATA_SIZE     = 64,
  parameter int CONTROL_SIZE  = 64,
  parameter int FRACTION_SIZE = 32,
  parameter bit SATURATE      = 1'b1
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  output logic                    READY,
  input  logic                    DATA_A_IN_I_ENABLE,
  input  logic                    DATA_A_IN_J_ENABLE,
  input  logic                    DATA_A_IN_K_ENABLE,
  input  logic                    DATA_B_IN_I_ENABLE,
  input  logic                    DATA_B_IN_J_ENABLE,
  input  logic                    DATA_B_IN_K_ENABLE,
  output logic                    DATA_OUT_I_ENABLE,
  output logic                    DATA_OUT_J_ENABLE,
  output logic                    DATA_OUT_K_ENABLE,
  input  logic [CONTROL_SIZE-1:0] SIZE_I_IN,
  input  logic [CONTROL_SIZE-1:0] SIZE_J_IN,
  input  logic [CONTROL_SIZE-1:0] SIZE_K_IN,
  input  logic [DATA_SIZE-1:0]    DATA_A_IN,
  input  logic [DATA_SIZE-1:0]    DATA_B_IN,
  output logic [DATA_SIZE-1:0]    DATA_OUT,
  output logic                    OVERFLOW,
  output logic                    INDEX_ERROR
);
  localparam int STAGES = 2;
  localparam logic [CONTROL_SIZE-1:0] ONE = {{(CONTROL_SIZE-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {STARTER_STATE, INPUT_STATE, ENDER_STATE} state_t;

  state_t state, state_nxt;
  logic [CONTROL_SIZE-1:0] size_i, size_j, size_k, i_cnt, j_cnt, k_cnt;
  logic [STAGES:1] vld_pipe;
  logic accept, load, zero_size, k_max, j_max, last_elem, exp_j, exp_i, marker_err;
  logic signed [2*DATA_SIZE-1:0] a_ext, b_ext, prod1;
  logic mj1, mi1, ierr1, ovf_s2;
  logic [DATA_SIZE-1:0] res_s2;

  assign zero_size = (SIZE_I_IN == '0) || (SIZE_J_IN == '0) || (SIZE_K_IN == '0);
  assign k_max     = (k_cnt == size_k - ONE);
  assign j_max     = (j_cnt == size_j - ONE);
  assign last_elem = k_max && j_max && (i_cnt == size_i - ONE);
  assign exp_j     = (k_cnt == '0);
  assign exp_i     = exp_j && (j_cnt == '0);
  assign marker_err = (DATA_A_IN_I_ENABLE != exp_i) || (DATA_A_IN_J_ENABLE != exp_j) ||
                      (DATA_B_IN_I_ENABLE != exp_i) || (DATA_B_IN_J_ENABLE != exp_j);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= STARTER_STATE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      STARTER_STATE: if (START) state_nxt = zero_size ? ENDER_STATE : INPUT_STATE;
      INPUT_STATE:   if (accept && last_elem) state_nxt = ENDER_STATE;
      ENDER_STATE:   if (READY) state_nxt = STARTER_STATE;
      default:       state_nxt = STARTER_STATE;
    endcase
  end

  always_comb begin
    load   = (state == STARTER_STATE) && START;
    accept = (state == INPUT_STATE) && DATA_A_IN_K_ENABLE && DATA_B_IN_K_ENABLE;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      size_i <= '0; size_j <= '0; size_k <= '0;
      i_cnt  <= '0; j_cnt  <= '0; k_cnt  <= '0;
    end else if (load) begin
      size_i <= SIZE_I_IN; size_j <= SIZE_J_IN; size_k <= SIZE_K_IN;
      i_cnt  <= '0; j_cnt  <= '0; k_cnt  <= '0;
    end else if (accept) begin
      if (!k_max) k_cnt <= k_cnt + ONE;
      else begin
        k_cnt <= '0;
        if (!j_max) j_cnt <= j_cnt + ONE;
        else begin
          j_cnt <= '0;
          i_cnt <= i_cnt + ONE;
        end
      end
    end
  end

  assign a_ext = {{DATA_SIZE{DATA_A_IN[DATA_SIZE-1]}}, DATA_A_IN};
  assign b_ext = {{DATA_SIZE{DATA_B_IN[DATA_SIZE-1]}}, DATA_B_IN};

  // stage 1: product plus markers regenerated from the counters
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      vld_pipe <= '0;
      prod1 <= '0; mj1 <= 1'b0; mi1 <= 1'b0; ierr1 <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], accept};
      if (accept) begin
        prod1 <= a_ext * b_ext;
        mj1   <= exp_j;
        mi1   <= exp_i;
        ierr1 <= marker_err;
      end
    end
  end

  fixed_round_sat #(
    .DATA_SIZE(DATA_SIZE), .FRACTION_SIZE(FRACTION_SIZE), .SATURATE(SATURATE)
  ) u_rs (
    .prod(prod1), .res(res_s2), .ovf(ovf_s2)
  );

  // stage 2: result, one-cycle enables, sticky status, READY
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      DATA_OUT <= '0; DATA_OUT_I_ENABLE <= 1'b0; DATA_OUT_J_ENABLE <= 1'b0;
      OVERFLOW <= 1'b0; INDEX_ERROR <= 1'b0; READY <= 1'b0;
    end else begin
      DATA_OUT_I_ENABLE <= vld_pipe[1] && mi1;
      DATA_OUT_J_ENABLE <= vld_pipe[1] && mj1;
      // ENDER holds at most the final element in stage 1, so READY lines up with it
      READY <= (state == ENDER_STATE) && !READY;
      if (vld_pipe[1]) DATA_OUT <= res_s2;
      if (load) begin
        OVERFLOW <= 1'b0; INDEX_ERROR <= 1'b0;
      end else if (vld_pipe[1]) begin
        if (ovf_s2) OVERFLOW    <= 1'b1;
        if (ierr1)  INDEX_ERROR <= 1'b1;
      end
    end
  end

  assign DATA_OUT_K_ENABLE = vld_pipe[STAGES];
endmodule

// File: tb/tb_accelerator_tensor_fixed_elementwise_multiplier.sv
// Scoreboard bench: saturating and wrapping instances share stimulus; Q8.8 reference model.

module tb_accelerator_tensor_fixed_elementwise_multiplier;
  localparam int DS = 16, CS = 16, FS = 8;

  logic CLK, RST, START;
  logic a_i, a_j, a_k, b_i, b_j, b_k;
  logic [CS-1:0] si, sj, sk;
  logic [DS-1:0] da, db;
  logic rdy_s, ie_s, je_s, ke_s, ov_s, ix_s;
  logic rdy_w, ie_w, je_w, ke_w, ov_w, ix_w;
  logic [DS-1:0] do_s, do_w;

  accelerator_tensor_fixed_elementwise_multiplier #(
    .DATA_SIZE(DS), .CONTROL_SIZE(CS), .FRACTION_SIZE(FS), .SATURATE(1'b1)
  ) u_sat (
    .CLK(CLK), .RST(RST), .START(START), .READY(rdy_s),
    .DATA_A_IN_I_ENABLE(a_i), .DATA_A_IN_J_ENABLE(a_j), .DATA_A_IN_K_ENABLE(a_k),
    .DATA_B_IN_I_ENABLE(b_i), .DATA_B_IN_J_ENABLE(b_j), .DATA_B_IN_K_ENABLE(b_k),
    .DATA_OUT_I_ENABLE(ie_s), .DATA_OUT_J_ENABLE(je_s), .DATA_OUT_K_ENABLE(ke_s),
    .SIZE_I_IN(si), .SIZE_J_IN(sj), .SIZE_K_IN(sk),
    .DATA_A_IN(da), .DATA_B_IN(db), .DATA_OUT(do_s),
    .OVERFLOW(ov_s), .INDEX_ERROR(ix_s)
  );

  accelerator_tensor_fixed_elementwise_multiplier #(
    .DATA_SIZE(DS), .CONTROL_SIZE(CS), .FRACTION_SIZE(FS), .SATURATE(1'b0)
  ) u_wrap (
    .CLK(CLK), .RST(RST), .START(START), .READY(rdy_w),
    .DATA_A_IN_I_ENABLE(a_i), .DATA_A_IN_J_ENABLE(a_j), .DATA_A_IN_K_ENABLE(a_k),
    .DATA_B_IN_I_ENABLE(b_i), .DATA_B_IN_J_ENABLE(b_j), .DATA_B_IN_K_ENABLE(b_k),
    .DATA_OUT_I_ENABLE(ie_w), .DATA_OUT_J_ENABLE(je_w), .DATA_OUT_K_ENABLE(ke_w),
    .SIZE_I_IN(si), .SIZE_J_IN(sj), .SIZE_K_IN(sk),
    .DATA_A_IN(da), .DATA_B_IN(db), .DATA_OUT(do_w),
    .OVERFLOW(ov_w), .INDEX_ERROR(ix_w)
  );

  typedef struct {
    logic [DS-1:0] ds, dw;
    bit ie, je, ovf, ierr, last;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int zq[$];
  logic [DS-1:0] dir_a[$], dir_b[$];
  int total = 0, bad = 0, cyc = 0;
  bit mon_en = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  // Q8.8 product, round half up, then clamp or wrap
  task automatic model(input logic [DS-1:0] a, input logic [DS-1:0] b,
                       output logic [DS-1:0] ds, output logic [DS-1:0] dw, output bit ov);
    longint p, r;
    p  = longint'($signed(a)) * longint'($signed(b));
    r  = (p + 128) >>> 8;
    ov = (r > 32767) || (r < -32768);
    dw = r[DS-1:0];
    ds = !ov ? r[DS-1:0] : (r > 0 ? 16'h7FFF : 16'h8000);
  endtask

  function automatic logic [DS-1:0] rnd16();
    int v;
    if ($urandom_range(0, 1) == 1) return DS'($urandom);
    v = $urandom_range(0, 2047) - 1024;
    return DS'(v);
  endfunction

  always @(negedge CLK) begin
    if (mon_en && RST) begin
      if (ke_s) begin
        if (sb.size() == 0) chk("spurious_out", {63'd0, ke_s}, 64'd0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("data_sat", do_s, e.ds);
          chk("data_wrap", do_w, e.dw);
          chk("k_en_wrap", ke_w, ke_s);
          chk("i_en", ie_s, e.ie);
          chk("j_en", je_s, e.je);
          chk("overflow", ov_s, e.ovf);
          chk("overflow_wrap", ov_w, e.ovf);
          chk("index_error", ix_s, e.ierr);
          chk("ready_last", rdy_s, e.last);
          chk("latency", cyc, e.cyc);
        end
      end else if (rdy_s) begin
        if (zq.size() > 0) chk("zero_ready_cyc", cyc, zq.pop_front());
        else chk("spurious_ready", rdy_s, 1'b0);
      end
      if (zq.size() > 0 && zq[0] < cyc) chk("zero_ready_late", cyc, zq.pop_front());
    end
  end

  task automatic idle_inputs();
    START = 0; a_i = 0; a_j = 0; a_k = 0; b_i = 0; b_j = 0; b_k = 0;
  endtask

  task automatic run(input int ni, input int nj, input int nk, input int bad_e, input int stall);
    int n, e, kk, jj;
    bit ierr, ovf;
    exp_t x;
    @(posedge CLK); #1;
    START = 1; si = CS'(ni); sj = CS'(nj); sk = CS'(nk);
    n = (ni == 0 || nj == 0 || nk == 0) ? 0 : ni * nj * nk;
    if (n == 0) zq.push_back(cyc + 2);
    ierr = 0; ovf = 0; e = 0;
    @(posedge CLK); #1;
    START = 0;
    while (e < n) begin
      da = rnd16(); db = rnd16();
      a_i = 1'($urandom); a_j = 1'($urandom); b_i = 1'($urandom); b_j = 1'($urandom);
      if (int'($urandom_range(0, 99)) < stall) begin
        a_k = 1'($urandom); b_k = ~a_k & 1'($urandom);
      end else begin
        if (dir_a.size() > 0) begin da = dir_a.pop_front(); db = dir_b.pop_front(); end
        kk = e % nk; jj = (e / nk) % nj;
        x.je = (kk == 0); x.ie = (kk == 0 && jj == 0);
        a_k = 1; b_k = 1;
        a_j = x.je; b_j = x.je; a_i = x.ie; b_i = x.ie;
        if (e == bad_e) begin a_j = ~x.je; ierr = 1; end
        model(da, db, x.ds, x.dw, x.ovf);
        ovf = ovf | x.ovf;
        x.ovf = ovf; x.ierr = ierr; x.last = (e == n - 1); x.cyc = cyc + 2;
        sb.push_back(x);
        e++;
      end
      @(posedge CLK); #1;
    end
    idle_inputs();
    for (int t = 0; t < 100 && (sb.size() != 0 || zq.size() != 0); t++) @(negedge CLK);
    chk("drain_timeout", sb.size() + zq.size(), 0);
  endtask

  initial begin
    RST = 0; idle_inputs(); si = 0; sj = 0; sk = 0; da = 0; db = 0;
    #2;
    chk("rst_ready", rdy_s, 0);
    chk("rst_k_en", ke_s, 0);
    chk("rst_data", do_s, 0);
    chk("rst_flags", {ov_s, ix_s, ov_w, ix_w}, 0);
    @(posedge CLK); #1; RST = 1;
    mon_en = 1;

    dir_a = '{16'h0180}; dir_b = '{16'h0200}; run(1, 1, 1, -1, 0);
    dir_a = '{16'h0001}; dir_b = '{16'h0080}; run(1, 1, 1, -1, 0);
    dir_a = '{16'hFF80}; dir_b = '{16'h0100}; run(1, 1, 1, -1, 0);
    dir_a = '{16'h7F00}; dir_b = '{16'h0200}; run(1, 1, 1, -1, 0);
    dir_a = '{16'h0100}; dir_b = '{16'h0100}; run(1, 1, 1, -1, 0);
    run(2, 2, 3, -1, 35);
    run(2, 2, 3, 1, 35);
    run(2, 0, 3, -1, 0);
    run(2, 2, 3, -1, 0);

    // abort a run part-way with reset
    mon_en = 0;
    @(posedge CLK); #1; START = 1; si = 2; sj = 2; sk = 3;
    @(posedge CLK); #1; START = 0;
    for (int e = 0; e < 5; e++) begin
      da = rnd16(); db = rnd16(); a_k = 1; b_k = 1;
      a_j = (e % 3 == 0); b_j = a_j; a_i = (e == 0); b_i = a_i;
      @(posedge CLK); #1;
    end
    RST = 0; #1;
    chk("abort_data", {do_s, do_w}, 0);
    chk("abort_en", {ie_s, je_s, ke_s, ie_w, je_w, ke_w}, 0);
    chk("abort_ready", {rdy_s, rdy_w}, 0);
    chk("abort_flags", {ov_s, ix_s, ov_w, ix_w}, 0);
    idle_inputs();
    for (int t = 0; t < 3; t++) begin
      @(negedge CLK);
      chk("abort_quiet", {rdy_s, ke_s}, 0);
    end
    @(posedge CLK); #1; RST = 1;
    sb.delete(); zq.delete(); mon_en = 1;
    for (int t = 0; t < 4; t++) begin
      @(negedge CLK);
      chk("post_rst_quiet", {rdy_s, ke_s}, 0);
    end
    run(2, 2, 3, -1, 25);

    for (int r = 0; r < 6; r++)
      run($urandom_range(1, 3), $urandom_range(1, 3), $urandom_range(1, 4),
          ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : -1, 20);

    repeat (4) @(posedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
